// File: rtl/edge_pkg.sv
// Shared types and widths for the SRAM burst read path.
// Holds the burst FSM state encoding and SRAM word geometry.
package edge_pkg;

  localparam int SRAM_ADDR_BITS = 16;
  localparam int SRAM_DATA_BITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } burst_state_t;

endpackage

// File: rtl/burst_fifo.sv
// Small synchronous FIFO buffering SRAM read words for the stream output.
// Ports: push/wdata write side, pop/rdata read side, full/empty status.
module burst_fifo #(
  parameter int DATA_BITS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 full,
  output logic                 empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          count;
  logic                 do_push;
  logic                 do_pop;

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A pop frees the head slot in the same cycle, so a
  // simultaneous push is accepted even when full.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read sequencer: one SRAM read per word, results buffered in a FIFO.
// Ports: req/base_addr/num_words in, busy/done status, SRAM handshake, stream.
module sram_burst_reader
  import edge_pkg::*;
#(
  parameter int ADDR_BITS  = SRAM_ADDR_BITS,
  parameter int DATA_BITS  = SRAM_DATA_BITS,
  parameter int LEN_BITS   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 req,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [LEN_BITS-1:0]  num_words,
  output logic                 busy,
  output logic                 done,
  output logic                 start,
  output logic                 writemode,
  output logic [ADDR_BITS-1:0] i_address,
  input  logic [DATA_BITS-1:0] i_r_data,
  input  logic                 io_done,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  burst_state_t         state;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [LEN_BITS-1:0]  remaining;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign writemode = 1'b0;
  assign out_valid = !empty;
  assign pop       = !empty && out_ready;
  // io_done outside WAIT belongs to no access of ours.
  assign push      = (state == WAIT) && io_done;

  burst_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (pop),
    .wdata (i_r_data),
    .rdata (out_data),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start     <= 1'b0;
      i_address <= '0;
    end else begin
      done  <= 1'b0;
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && num_words != '0) begin
            cur_addr  <= base_addr;
            remaining <= num_words;
            busy      <= 1'b1;
            state     <= ISSUE;
          end else if (req) begin
            done <= 1'b1;
          end
        end
        ISSUE: begin
          // Issue only with a free slot so the
          // returning word always fits.
          if (!full) begin
            start     <= 1'b1;
            i_address <= cur_addr;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (io_done) begin
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_BITS'(1)) begin
              state <= DRAIN;
            end else begin
              state <= ISSUE;
            end
          end
        end
        DRAIN: begin
          if (empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Scoreboard bench for sram_burst_reader with a 13-cycle SRAM model.
// Expected addresses/words are queued at stimulus, checked by a monitor.
module tb_sram_burst_reader;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy;
  logic        done;
  logic        start;
  logic        writemode;
  logic [15:0] i_address;
  logic [31:0] i_r_data = 32'hDEAD_BEEF;
  logic        io_done = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  sram_burst_reader dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (req),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .start     (start),
    .writemode (writemode),
    .i_address (i_address),
    .i_r_data  (i_r_data),
    .io_done   (io_done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int busy_seen = 0;

  logic [15:0] exp_addr [$];
  logic [31:0] exp_data [$];

  function automatic logic [31:0] word_of(input logic [15:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_burst(input logic [15:0] b, input int n);
    logic [15:0] a;
    a = b;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a);
      exp_data.push_back(word_of(a));
      a = a + 16'd1;
    end
  endtask

  task automatic issue(input logic [15:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    req = 1'b1;
    base_addr = b;
    num_words = n;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && done !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      checks++;
      $display("FAIL %s: done not seen in %0d cycles", name, budget);
    end
  endtask

  // SRAM model: answers each start 13 cycles later.
  logic        pend = 1'b0;
  int          cd = 0;
  logic [15:0] pend_addr = '0;
  initial forever begin
    @(negedge clk);
    if (!n_rst) begin
      pend = 1'b0;
      io_done = 1'b0;
      i_r_data = 32'hDEAD_BEEF;
    end else begin
      io_done = 1'b0;
      i_r_data = 32'hDEAD_BEEF;
      if (pend) begin
        check("addr_stable", i_address, pend_addr);
        cd--;
        if (cd == 0) begin
          io_done = 1'b1;
          i_r_data = word_of(pend_addr);
          pend = 1'b0;
        end
      end
      if (start) begin
        check("one_outstanding", pend, 1'b0);
        check("writemode", writemode, 1'b0);
        pend = 1'b1;
        cd = 12;
        pend_addr = i_address;
      end
    end
  end

  // Monitor / scoreboard.
  logic prev_start = 1'b0;
  initial forever begin
    @(negedge clk);
    if (n_rst) begin
      if (start) begin
        start_cnt++;
        check("start_width", prev_start, 1'b0);
        if (exp_addr.size() == 0) begin
          checks++;
          $display("FAIL start_addr: unexpected start at %h", i_address);
        end else begin
          check("start_addr", i_address, exp_addr.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          $display("FAIL out_data: unexpected word %h", out_data);
        end else begin
          check("out_data", out_data, exp_data.pop_front());
        end
      end
      if (done) done_cnt++;
      if (busy) busy_seen++;
      prev_start = start;
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int d0, s0, b0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_start", start, 1'b0);
    check("rst_addr", i_address, 16'h0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 32'h0);
    n_rst = 1'b1;
    out_ready = 1'b1;

    // 1: basic burst of 3, req-to-start latency 2
    d0 = done_cnt; s0 = start_cnt;
    expect_burst(16'h0010, 3);
    @(posedge clk); #1;
    req = 1'b1; base_addr = 16'h0010; num_words = 16'd3;
    @(negedge clk);
    check("t1_start_n1", start, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("t1_busy", busy, 1'b1);
    check("t1_start_n2", start, 1'b0);
    @(negedge clk);
    check("t1_latency", start, 1'b1);
    wait_done("t1_done", 200);
    repeat (5) @(negedge clk);
    check("t1_busy_end", busy, 1'b0);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_starts", start_cnt - s0, 3);
    check("t1_q_addr", exp_addr.size(), 0);
    check("t1_q_data", exp_data.size(), 0);

    // 2: zero-length request
    d0 = done_cnt; s0 = start_cnt; b0 = busy_seen;
    @(posedge clk); #1;
    req = 1'b1; base_addr = 16'h1234; num_words = 16'd0;
    @(negedge clk);
    check("t2_done_early", done, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("t2_done", done, 1'b1);
    @(negedge clk);
    check("t2_done_pulse", done, 1'b0);
    repeat (10) @(negedge clk);
    check("t2_busy", busy_seen - b0, 0);
    check("t2_starts", start_cnt - s0, 0);
    check("t2_done_cnt", done_cnt - d0, 1);

    // 3: address wrap
    d0 = done_cnt; s0 = start_cnt;
    expect_burst(16'hFFFE, 3);
    issue(16'hFFFE, 16'd3);
    wait_done("t3_done", 200);
    repeat (5) @(negedge clk);
    check("t3_done_cnt", done_cnt - d0, 1);
    check("t3_starts", start_cnt - s0, 3);
    check("t3_q_addr", exp_addr.size(), 0);
    check("t3_q_data", exp_data.size(), 0);

    // 4: backpressure fills the FIFO, then release
    d0 = done_cnt; s0 = start_cnt;
    out_ready = 1'b0;
    expect_burst(16'h0100, 8);
    issue(16'h0100, 16'd8);
    repeat (4 * 16 + 40) @(negedge clk);
    check("t4_stall_starts", start_cnt - s0, 4);
    check("t4_valid", out_valid, 1'b1);
    check("t4_head", out_data, 32'hFEFF_0100);
    check("t4_busy", busy, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_head_hold", out_data, 32'hFEFF_0100);
    check("t4_still_4", start_cnt - s0, 4);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("t4_done", 400);
    repeat (5) @(negedge clk);
    check("t4_done_cnt", done_cnt - d0, 1);
    check("t4_starts", start_cnt - s0, 8);
    check("t4_q_addr", exp_addr.size(), 0);
    check("t4_q_data", exp_data.size(), 0);

    // 5: req while busy is ignored
    d0 = done_cnt; s0 = start_cnt;
    expect_burst(16'h0200, 3);
    issue(16'h0200, 16'd3);
    repeat (5) @(posedge clk);
    #1;
    check("t5_busy", busy, 1'b1);
    req = 1'b1; base_addr = 16'h0300; num_words = 16'd5;
    @(posedge clk); #1;
    req = 1'b0;
    wait_done("t5_done", 200);
    repeat (5) @(negedge clk);
    check("t5_done_cnt", done_cnt - d0, 1);
    check("t5_starts", start_cnt - s0, 3);
    check("t5_q_addr", exp_addr.size(), 0);

    // 6: reset during WAIT of word 2 of 5
    d0 = done_cnt; s0 = start_cnt;
    expect_burst(16'h0400, 5);
    issue(16'h0400, 16'd5);
    for (int k = 0; k < 200 && start_cnt - s0 < 2; k++) begin
      @(negedge clk);
    end
    check("t6_reach_w2", start_cnt - s0, 2);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_start", start, 1'b0);
    check("t6_addr", i_address, 16'h0000);
    check("t6_valid", out_valid, 1'b0);
    check("t6_data", out_data, 32'h0);
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    s0 = start_cnt;
    repeat (30) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_no_start", start_cnt - s0, 0);
    expect_burst(16'h0500, 2);
    issue(16'h0500, 16'd2);
    wait_done("t6_new_done", 200);
    repeat (5) @(negedge clk);
    check("t6_new_cnt", done_cnt - d0, 1);
    check("t6_new_starts", start_cnt - s0, 2);
    check("t6_q_addr", exp_addr.size(), 0);
    check("t6_q_data", exp_data.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
